// File: rtl/drop_gate_ctrl.sv
// Timed drop-gate sequencer: arm delay, gate-open window, cooldown lockout.
// Optional DROP_COUNT_EN adds a saturating completed-drop counter output.
//
// state    | meaning
// IDLE     | waiting for a fresh drop request
// ARM      | counting down the drop delay (t_act ticks)
// OPEN     | gate driven open for OPEN_TICKS ticks
// COOLDOWN | lockout for COOLDOWN_TICKS ticks, requests ignored
module drop_gate_ctrl #(
  parameter int CLK_PER_TICK   = 1000,
  parameter int OPEN_TICKS     = 16,
  parameter int COOLDOWN_TICKS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        drop_activated,
  input  logic [15:0] t_act,
  input  logic        drop_en,
  input  logic        abort,
  output logic        gate_open,
  output logic        busy,
  output logic        done,
  output logic [15:0] remaining,
  output logic [1:0]  state
`ifdef DROP_COUNT_EN
  ,
  output logic [7:0]  drop_count
`endif
);

  localparam int PW = (CLK_PER_TICK > 2) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_TICK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_OPEN = 2'd2,
    S_COOL = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc;
  logic          tick;
  logic          rearm;
  logic          capture;
  logic          done_d;
  logic [15:0]   rem_d;
  logic          cancel;

  assign state  = state_q;
  assign tick   = (presc == PRESC_LAST);
  assign cancel = abort | ~drop_en;

  always_comb begin
    state_d = state_q;
    rem_d   = remaining;
    done_d  = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        rem_d = 16'd0;
        if (drop_en && drop_activated && rearm && !abort) begin
          capture = 1'b1;
          if (t_act == 16'd0) begin
            state_d = S_OPEN;
            rem_d   = 16'(OPEN_TICKS);
          end else begin
            state_d = S_ARM;
            rem_d   = t_act;
          end
        end
      end
      S_ARM: begin
        if (cancel) begin
          state_d = S_IDLE;
          rem_d   = 16'd0;
        end else if (tick) begin
          if (remaining <= 16'd1) begin
            state_d = S_OPEN;
            rem_d   = 16'(OPEN_TICKS);
          end else begin
            rem_d = remaining - 16'd1;
          end
        end
      end
      S_OPEN: begin
        // a cancel closes the gate early and still serves the full cooldown
        if (cancel) begin
          state_d = S_COOL;
          rem_d   = 16'(COOLDOWN_TICKS);
        end else if (tick) begin
          if (remaining <= 16'd1) begin
            state_d = S_COOL;
            rem_d   = 16'(COOLDOWN_TICKS);
            done_d  = 1'b1;
          end else begin
            rem_d = remaining - 16'd1;
          end
        end
      end
      S_COOL: begin
        if (tick) begin
          if (remaining <= 16'd1) begin
            state_d = S_IDLE;
            rem_d   = 16'd0;
          end else begin
            rem_d = remaining - 16'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        rem_d   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      remaining <= 16'd0;
      presc     <= '0;
      rearm     <= 1'b1;
      gate_open <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      remaining <= rem_d;
      gate_open <= (state_d == S_OPEN);
      busy      <= (state_d != S_IDLE);
      done      <= done_d;
      // prescaler restarts on every state entry so each phase is whole ticks
      if (state_d != state_q || tick)
        presc <= '0;
      else
        presc <= presc + PW'(1);
      if (capture)
        rearm <= 1'b0;
      else if (state_q == S_IDLE && !drop_activated)
        rearm <= 1'b1;
    end
  end

`ifdef DROP_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_count <= 8'd0;
    else if (done_d && drop_count != 8'hFF)
      drop_count <= drop_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_drop_gate_ctrl.sv
// Directed bench for drop_gate_ctrl with short ticks (4 clk/tick, open 2, cooldown 1).
module tb_drop_gate_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        drop_activated = 1'b0;
  logic [15:0] t_act = 16'd0;
  logic        drop_en = 1'b1;
  logic        abort = 1'b0;
  logic        gate_open, busy, done;
  logic [15:0] remaining;
  logic [1:0]  state;
`ifdef DROP_COUNT_EN
  logic [7:0]  drop_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;
  int gate_seen = 0;
  int exp_count = 0;
  int n;

  localparam logic [1:0] ST_IDLE = 2'd0, ST_ARM = 2'd1, ST_OPEN = 2'd2, ST_COOL = 2'd3;

  drop_gate_ctrl #(.CLK_PER_TICK(4), .OPEN_TICKS(2), .COOLDOWN_TICKS(1)) dut (
    .clk(clk), .rst_n(rst_n), .drop_activated(drop_activated), .t_act(t_act),
    .drop_en(drop_en), .abort(abort), .gate_open(gate_open), .busy(busy),
    .done(done), .remaining(remaining), .state(state)
`ifdef DROP_COUNT_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sample_step();
    if (done) done_seen++;
    if (gate_open) gate_seen++;
    @(negedge clk);
  endtask

  task automatic cycles(input int k);
    repeat (k) sample_step();
  endtask

  task automatic run_phase(input logic [1:0] st, output int cnt);
    cnt = 0;
    while (state == st && cnt < 2000) begin
      cnt++;
      sample_step();
    end
  endtask

  // two idle cycles with drop_activated low to rearm, then a one-cycle request
  task automatic req(input logic [15:0] t);
    @(negedge clk);
    @(negedge clk);
    t_act = t;
    drop_activated = 1'b1;
    @(negedge clk);
    drop_activated = 1'b0;
    t_act = 16'hBEEF;
  endtask

  initial begin
    #12;
    chk_val("rst_state", state, ST_IDLE);
    chk_val("rst_gate", gate_open, 0);
    chk_val("rst_busy", busy, 0);
    chk_val("rst_rem", remaining, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic sequence t_act=3
    done_seen = 0; gate_seen = 0;
    req(16'd3);
    chk_val("arm_state", state, ST_ARM);
    chk_val("arm_rem", remaining, 3);
    chk_val("arm_busy", busy, 1);
    run_phase(ST_ARM, n);
    chk_val("arm_len", n, 12);
    chk_val("open_rem", remaining, 2);
    run_phase(ST_OPEN, n);
    chk_val("open_len", n, 8);
    chk_val("done_at_cool", done, 1);
    chk_val("cool_rem", remaining, 1);
    run_phase(ST_COOL, n);
    chk_val("cool_len", n, 4);
    chk_val("t1_gate_cycles", gate_seen, 8);
    chk_val("t1_done_cycles", done_seen, 1);
    chk_val("t1_idle_busy", busy, 0);
    chk_val("t1_idle_rem", remaining, 0);
    exp_count = 1;

    // t_act=0 goes straight to OPEN; abort during cooldown is ignored
    done_seen = 0; gate_seen = 0;
    req(16'd0);
    chk_val("t0_state", state, ST_OPEN);
    chk_val("t0_gate", gate_open, 1);
    run_phase(ST_OPEN, n);
    chk_val("t0_open_len", n, 8);
    abort = 1'b1;
    run_phase(ST_COOL, n);
    abort = 1'b0;
    chk_val("t0_cool_abort_len", n, 4);
    chk_val("t0_gate_cycles", gate_seen, 8);
    chk_val("t0_done_cycles", done_seen, 1);
    exp_count = 2;

    // level held high yields a single drop
    @(negedge clk);
    done_seen = 0;
    t_act = 16'd1;
    drop_activated = 1'b1;
    cycles(60);
    chk_val("hold_done_cnt", done_seen, 1);
    chk_val("hold_state", state, ST_IDLE);
    drop_activated = 1'b0;
    @(negedge clk);
    drop_activated = 1'b1;
    done_seen = 0;
    cycles(30);
    chk_val("retrig_done_cnt", done_seen, 1);
    drop_activated = 1'b0;
    exp_count = 4;

    // abort together with a request in IDLE: no capture
    @(negedge clk);
    @(negedge clk);
    drop_activated = 1'b1;
    t_act = 16'd2;
    abort = 1'b1;
    @(negedge clk);
    chk_val("idle_abort_state", state, ST_IDLE);
    abort = 1'b0;
    drop_activated = 1'b0;

    // abort 5 cycles into ARM
    req(16'd3);
    done_seen = 0; gate_seen = 0;
    cycles(4);
    abort = 1'b1;
    cycles(1);
    abort = 1'b0;
    chk_val("arm_abort_state", state, ST_IDLE);
    chk_val("arm_abort_rem", remaining, 0);
    chk_val("arm_abort_busy", busy, 0);
    cycles(20);
    chk_val("arm_abort_gate", gate_seen, 0);
    chk_val("arm_abort_done", done_seen, 0);

    // drop_en low during OPEN
    req(16'd0);
    cycles(2);
    drop_en = 1'b0;
    cycles(1);
    drop_en = 1'b1;
    chk_val("en_off_state", state, ST_COOL);
    chk_val("en_off_gate", gate_open, 0);
    done_seen = 0;
    run_phase(ST_COOL, n);
    chk_val("en_off_cool_len", n, 4);
    chk_val("en_off_done", done_seen, 0);
`ifdef DROP_COUNT_EN
    chk_val("count_after_abort", drop_count, exp_count);
`endif

    // async reset while gate open
    req(16'd0);
    chk_val("pre_rst_gate", gate_open, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_val("async_rst_gate", gate_open, 0);
    chk_val("async_rst_state", state, ST_IDLE);
    chk_val("async_rst_busy", busy, 0);
    chk_val("async_rst_rem", remaining, 0);
    chk_val("async_rst_done", done, 0);
`ifdef DROP_COUNT_EN
    chk_val("async_rst_count", drop_count, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

`ifdef DROP_COUNT_EN
    for (int i = 0; i < 256; i++) begin
      req(16'd0);
      run_phase(ST_OPEN, n);
      run_phase(ST_COOL, n);
    end
    chk_val("count_sat", drop_count, 255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
